apb_uart_host: RTL and testbench

APB_UART_HOST -- requirements
Module: apb_uart_host

---
 rtl/apb_uart_host_pkg.sv | 15 +
 rtl/apb_uart_host_xfer.sv | 44 ++++
 rtl/apb_uart_host.sv | 94 +++++++++
 tb/tb_apb_uart_host.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/apb_uart_host_pkg.sv
// apb_uart_host_pkg: UART register offsets, STATUS bit positions and host FSM states
package apb_uart_host_pkg;
  localparam logic [4:0] REG_TXDATA = 5'h00;
  localparam logic [4:0] REG_RXDATA = 5'h04;
  localparam logic [4:0] REG_CTRL1  = 5'h08;
  localparam logic [4:0] REG_CTRL2  = 5'h0C;
  localparam logic [4:0] REG_STATUS = 5'h10;
  localparam logic [4:0] REG_CTRL3  = 5'h14;
  localparam int ST_TXRDY = 0;
  localparam int ST_RXRDY = 1;
  localparam int ST_PAR   = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_FRM   = 4;
  typedef enum logic [2:0] {CFG1, CFG2, CFG3, POLL, RDRX, WRTX} state_t;
endpackage

// File: rtl/apb_uart_host_xfer.sv
// apb_uart_host_xfer: one APB transfer (SETUP then ACCESS until PREADY) per start while idle
module apb_uart_host_xfer (
  input  logic       PCLK,
  input  logic       PRESETN,
  input  logic       start,
  input  logic [4:0] addr,
  input  logic       write,
  input  logic [7:0] wdata,
  output logic       done,
  output logic [7:0] rdata,
  output logic       slverr,
  output logic [4:0] PADDR,
  output logic       PSEL,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA,
  input  logic       PREADY,
  input  logic       PSLVERR
);
  // address, direction and data are captured once at SETUP and held until completion
  always_ff @(posedge PCLK)
    if (!PRESETN) begin
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PADDR   <= 5'h00;
      PWDATA  <= 8'h00;
    end else if (!PSEL) begin
      if (start) begin
        PSEL   <= 1'b1;
        PWRITE <= write;
        PADDR  <= addr;
        PWDATA <= write ? wdata : 8'h00;
      end
    end else if (!PENABLE) PENABLE <= 1'b1;
    else if (PREADY) begin
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
    end
  assign done   = PSEL && PENABLE && PREADY;
  assign rdata  = PRDATA;
  assign slverr = PSLVERR;
endmodule

// File: rtl/apb_uart_host.sv
// apb_uart_host: APB master that configures a UART, then polls STATUS to move RX/TX bytes
module apb_uart_host
  import apb_uart_host_pkg::*;
#(
  parameter logic [12:0] BAUD_VAL = 13'd1,
  parameter logic [2:0]  CTRL2_LO = 3'b001,
  parameter logic [2:0]  FRAC_VAL = 3'd0
) (
  input  logic       PCLK,
  input  logic       PRESETN,
  output logic [4:0] PADDR,
  output logic       PSEL,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA,
  input  logic       PREADY,
  input  logic       PSLVERR,
  input  logic       TX_VALID,
  input  logic [7:0] TX_DATA,
  output logic       TX_READY,
  output logic       RX_VALID,
  output logic [7:0] RX_DATA,
  input  logic       RX_READY,
  output logic       CFG_DONE,
  output logic [3:0] ERR_STICKY,
  input  logic       ERR_CLR
);
  state_t state, state_nxt;
  logic start, write, done, slverr;
  logic [4:0] addr;
  logic [7:0] wdata, rdata;
  apb_uart_host_xfer u_xfer (
    .PCLK(PCLK), .PRESETN(PRESETN), .start(start), .addr(addr), .write(write), .wdata(wdata),
    .done(done), .rdata(rdata), .slverr(slverr), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );
  always_ff @(posedge PCLK) state <= !PRESETN ? CFG1 : state_nxt;
  // RX wins over TX, and a held RX byte blocks further RXDATA reads
  always_comb begin
    state_nxt = state;
    if (done)
      case (state)
        CFG1:    state_nxt = CFG2;
        CFG2:    state_nxt = CFG3;
        CFG3:    state_nxt = POLL;
        POLL:    state_nxt = rdata[ST_RXRDY] && !RX_VALID ? RDRX :
                             rdata[ST_TXRDY] && TX_VALID ? WRTX : POLL;
        default: state_nxt = POLL;
      endcase
  end
  always_comb begin
    start = !PSEL;
    write = state != POLL && state != RDRX;
    addr  = REG_STATUS;
    wdata = 8'h00;
    case (state)
      CFG1: begin
        addr  = REG_CTRL1;
        wdata = BAUD_VAL[7:0];
      end
      CFG2: begin
        addr  = REG_CTRL2;
        wdata = {BAUD_VAL[12:8], CTRL2_LO};
      end
      CFG3: begin
        addr  = REG_CTRL3;
        wdata = {5'b0, FRAC_VAL};
      end
      RDRX: addr = REG_RXDATA;
      WRTX: begin
        addr  = REG_TXDATA;
        wdata = TX_DATA;
      end
      default: ;
    endcase
  end
  assign TX_READY = PSEL && !PENABLE && state == WRTX;
  always_ff @(posedge PCLK)
    if (!PRESETN) begin
      CFG_DONE   <= 1'b0;
      RX_VALID   <= 1'b0;
      RX_DATA    <= 8'h00;
      ERR_STICKY <= 4'h0;
    end else begin
      if (done && state == CFG3) CFG_DONE <= 1'b1;
      if (done && state == RDRX) begin
        RX_VALID <= 1'b1;
        RX_DATA  <= rdata;
      end else if (RX_READY) RX_VALID <= 1'b0;
      ERR_STICKY <= (ERR_CLR ? 4'h0 : ERR_STICKY) |
                    {done && slverr, done && state == POLL ? {rdata[ST_FRM], rdata[ST_OVF], rdata[ST_PAR]} : 3'b000};
    end
endmodule

// File: tb/tb_apb_uart_host.sv
// tb_apb_uart_host: APB slave stub plus transaction-level model of the host, checked every cycle
module tb_apb_uart_host;
  localparam logic [12:0] BAUD = 13'h123;
  localparam logic [2:0] C2LO = 3'b011;
  localparam logic [2:0] FRAC = 3'd3;
  typedef struct packed {logic [4:0] a; logic w; logic [7:0] d;} xfer_t;

  logic PCLK = 1'b0, PRESETN = 1'b0;
  logic [4:0] PADDR;
  logic PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [7:0] PWDATA, PRDATA;
  logic TX_VALID = 1'b0, TX_READY, RX_VALID, RX_READY = 1'b0, CFG_DONE, ERR_CLR = 1'b0;
  logic [7:0] TX_DATA = 8'h00, RX_DATA;
  logic [3:0] ERR_STICKY;
  always #5 PCLK = ~PCLK;

  apb_uart_host #(.BAUD_VAL(BAUD), .CTRL2_LO(C2LO), .FRAC_VAL(FRAC)) dut (
    .PCLK(PCLK), .PRESETN(PRESETN), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .TX_VALID(TX_VALID), .TX_DATA(TX_DATA), .TX_READY(TX_READY), .RX_VALID(RX_VALID),
    .RX_DATA(RX_DATA), .RX_READY(RX_READY), .CFG_DONE(CFG_DONE), .ERR_STICKY(ERR_STICKY),
    .ERR_CLR(ERR_CLR)
  );

  // slave stub: PREADY held low for 'stall' ACCESS cycles
  logic [7:0] status = 8'h00, rx_byte = 8'h00;
  logic slverr = 1'b0;
  int stall = 0, acc = 0;
  assign PREADY  = !(PSEL && PENABLE) || acc >= stall;
  assign PRDATA  = PADDR == 5'h10 ? status : PADDR == 5'h04 ? rx_byte : 8'h00;
  assign PSLVERR = slverr;
  always @(posedge PCLK) acc <= (PSEL && PENABLE && !PREADY) ? acc + 1 : 0;

  int errors = 0, checks = 0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  xfer_t exp_q[$], log_q[$];
  xfer_t e;
  logic known = 1'b0, rst_edge = 1'b0, m_cfg = 1'b0, m_rxv = 1'b0;
  logic [7:0] m_rxd = 8'h00, tx_acc = 8'h00;
  logic [3:0] m_err = 4'h0;
  logic p_sel = 1'b0, p_en = 1'b0, p_rdy = 1'b0, p_wr = 1'b0;
  logic [4:0] p_addr = 5'h00;
  logic [7:0] p_wd = 8'h00;
  int tx_pulses = 0, acc_len = 0, last_len = 0;

  // model state reflects all edges so far; check first, then advance for the coming edge
  always @(negedge PCLK) begin
    if (known) begin
      chk("cfg_done", CFG_DONE, m_cfg);
      chk("rx_valid", RX_VALID, m_rxv);
      if (m_rxv || rst_edge) chk("rx_data", RX_DATA, m_rxd);
      chk("err_sticky", ERR_STICKY, m_err);
      if (rst_edge) chk("reset_outs", {PSEL, PENABLE, PWRITE, PADDR, PWDATA, TX_READY}, 0);
      else if (p_sel && !(p_en && p_rdy))
        chk("access_hold", {PSEL, PENABLE, PADDR, PWRITE, PWDATA}, {2'b11, p_addr, p_wr, p_wd});
      else chk("setup_first", PENABLE, 1'b0);
      if (PSEL && !PWRITE) chk("rd_wdata_zero", PWDATA, 8'h00);
      if (TX_READY) begin
        chk("tx_ready_setup", {PSEL, PENABLE, PWRITE, PADDR}, {3'b101, 5'h00});
        chk("tx_valid_hs", TX_VALID, 1'b1);
        tx_acc = TX_DATA;
        tx_pulses++;
      end
    end
    if (!PRESETN) begin
      known = 1'b1; rst_edge = 1'b1; m_cfg = 1'b0; m_rxv = 1'b0; m_rxd = 8'h00; m_err = 4'h0;
      exp_q.delete();
      exp_q.push_back({5'h08, 1'b1, BAUD[7:0]});
      exp_q.push_back({5'h0C, 1'b1, BAUD[12:8], C2LO});
      exp_q.push_back({5'h14, 1'b1, 5'b0, FRAC});
      p_sel = 1'b0; p_en = 1'b0; p_rdy = 1'b0; tx_pulses = 0; acc_len = 0;
    end else if (known) begin
      rst_edge = 1'b0;
      if (ERR_CLR) m_err = 4'h0;
      if (PSEL && PENABLE) acc_len++;
      if (PSEL && PENABLE && PREADY) begin
        if (exp_q.size() == 0) chk("unexpected_xfer", {PADDR, PWRITE}, 0);
        else begin
          e = exp_q.pop_front();
          chk("xfer_addr", PADDR, e.a);
          chk("xfer_write", PWRITE, e.w);
          if (e.w) chk("xfer_wdata", PWDATA, e.d);
        end
        log_q.push_back({PADDR, PWRITE, PWRITE ? PWDATA : PRDATA});
        last_len = acc_len;
        acc_len = 0;
        if (PSLVERR) m_err[3] = 1'b1;
        if (PADDR == 5'h10 && !PWRITE) begin
          m_err[2:0] = m_err[2:0] | {PRDATA[4], PRDATA[3], PRDATA[2]};
          if (PRDATA[1] && !m_rxv) exp_q.push_back({5'h04, 1'b0, 8'h00});
          else if (PRDATA[0] && TX_VALID) exp_q.push_back({5'h00, 1'b1, TX_DATA});
          else exp_q.push_back({5'h10, 1'b0, 8'h00});
        end
        if (PADDR == 5'h00 && PWRITE) begin
          chk("tx_pulses", tx_pulses, 1);
          chk("tx_wdata_hs", PWDATA, tx_acc);
          tx_pulses = 0;
        end
        if (PADDR == 5'h14 && PWRITE) m_cfg = 1'b1;
        if ((PADDR == 5'h14 && PWRITE) || (PADDR == 5'h00 && PWRITE) || (PADDR == 5'h04 && !PWRITE))
          exp_q.push_back({5'h10, 1'b0, 8'h00});
      end
      if (m_rxv && RX_READY) m_rxv = 1'b0;
      if (PSEL && PENABLE && PREADY && PADDR == 5'h04 && !PWRITE) begin
        m_rxv = 1'b1;
        m_rxd = PRDATA;
      end
      p_sel = PSEL; p_en = PENABLE; p_rdy = PREADY; p_wr = PWRITE; p_addr = PADDR; p_wd = PWDATA;
    end
  end

  task automatic drive_edge();
    @(posedge PCLK);
    #1;
  endtask
  task automatic wait_log(int n, int max, string what);
    for (int i = 0; i < max && log_q.size() < n; i++) @(negedge PCLK);
    chk(what, log_q.size() >= n, 1'b1);
  endtask
  task automatic wait_tx(int max);
    for (int i = 0; i < max && !TX_READY; i++) @(negedge PCLK);
    chk("tx_ready_seen", TX_READY, 1'b1);
    drive_edge();
    TX_VALID = 1'b0;
  endtask

  int n, i04, i00, cnt, polls;
  initial begin
    repeat (3) @(posedge PCLK);
    #1 PRESETN = 1'b1;
    wait_log(4, 40, "cfg_timeout");
    chk("cfg1_lit", log_q[0], {5'h08, 1'b1, 8'h23});
    chk("cfg2_lit", log_q[1], {5'h0C, 1'b1, 8'h0B});
    chk("cfg3_lit", log_q[2], {5'h14, 1'b1, 8'h03});
    chk("poll_lit", {log_q[3].a, log_q[3].w}, {5'h10, 1'b0});
    chk("cfg_done_lit", CFG_DONE, 1'b1);

    drive_edge();
    status = 8'h01; TX_VALID = 1'b1; TX_DATA = 8'h5A;
    wait_tx(40);
    status = 8'h00;
    repeat (6) @(negedge PCLK);
    i00 = -1;
    foreach (log_q[k]) if (log_q[k].a == 5'h00 && log_q[k].w) i00 = k;
    chk("tx_write_lit", i00 >= 0 ? log_q[i00].d : 8'hxx, 8'h5A);

    drive_edge();
    n = log_q.size();
    status = 8'h03; TX_VALID = 1'b1; TX_DATA = 8'h77; rx_byte = 8'hC3;
    wait_tx(60);
    status = 8'h02;
    repeat (6) @(negedge PCLK);
    i04 = -1; i00 = -1;
    for (int k = n; k < log_q.size(); k++) begin
      if (log_q[k].a == 5'h04 && !log_q[k].w && i04 < 0) i04 = k;
      if (log_q[k].a == 5'h00 && log_q[k].w && i00 < 0) i00 = k;
    end
    chk("rx_before_tx", i04 >= 0 && i00 > i04, 1'b1);
    chk("rx_valid_lit", RX_VALID, 1'b1);
    chk("rx_data_lit", RX_DATA, 8'hC3);

    n = log_q.size();
    repeat (30) @(negedge PCLK);
    cnt = 0; polls = 0;
    for (int k = n; k < log_q.size(); k++) begin
      if (log_q[k].a == 5'h04) cnt++;
      if (log_q[k].a == 5'h10) polls++;
    end
    chk("held_no_rxread", cnt, 0);
    chk("held_polls", polls >= 5, 1'b1);
    drive_edge();
    RX_READY = 1'b1; rx_byte = 8'h3C;
    drive_edge();
    RX_READY = 1'b0;
    for (int i = 0; i < 40 && !RX_VALID; i++) @(negedge PCLK);
    chk("rx_reload_lit", {RX_VALID, RX_DATA}, {1'b1, 8'h3C});
    drive_edge();
    status = 8'h00;

    status = 8'h1C;
    wait_log(log_q.size() + 2, 40, "err_poll_timeout");
    drive_edge();
    status = 8'h00;
    @(negedge PCLK);
    chk("status_err_lit", ERR_STICKY, 4'b0111);
    drive_edge();
    ERR_CLR = 1'b1;
    drive_edge();
    ERR_CLR = 1'b0;
    @(negedge PCLK);
    chk("err_clr_lit", ERR_STICKY, 4'b0000);

    for (int i = 0; i < 20 && PSEL; i++) @(negedge PCLK);
    drive_edge();
    stall = 5; slverr = 1'b1;
    wait_log(log_q.size() + 1, 50, "stall_timeout");
    drive_edge();
    stall = 0; slverr = 1'b0;
    @(negedge PCLK);
    chk("stall_len_lit", last_len, 6);
    chk("slverr_lit", ERR_STICKY, 4'b1000);
    drive_edge();
    ERR_CLR = 1'b1;
    drive_edge();
    ERR_CLR = 1'b0;
    @(negedge PCLK);
    chk("slverr_clr_lit", ERR_STICKY, 4'b0000);

    drive_edge();
    stall = 20;
    for (int i = 0; i < 30 && !(PSEL && PENABLE); i++) @(negedge PCLK);
    chk("access_seen", PSEL && PENABLE, 1'b1);
    n = log_q.size();
    drive_edge();
    PRESETN = 1'b0;
    drive_edge();
    PRESETN = 1'b1; stall = 0;
    @(negedge PCLK);
    chk("reset_psel_lit", {PSEL, CFG_DONE}, 2'b00);
    wait_log(n + 4, 40, "recfg_timeout");
    chk("recfg1_lit", log_q[n], {5'h08, 1'b1, 8'h23});
    chk("recfg_done_lit", CFG_DONE, 1'b1);
    repeat (5) @(negedge PCLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
